// File: rtl/mult_dispatch.sv
// mult_dispatch: FIFO-buffered operand sequencer and result collector around a Booth multiplier.
// One job is in flight at a time. Its FIFO slot is released only when the job leaves WAIT.
module mult_dispatch #(
  parameter int WIDTH      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 31
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic [WIDTH-1:0]     mul_multiplicand,
  output logic [WIDTH-1:0]     mul_multiplier,
  output logic                 mul_start,
  input  logic [2*WIDTH-1:0]   mul_result,
  input  logic                 mul_finished,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_result,
  output logic                 out_timeout,
  output logic                 busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, START, WAIT, OUT} state_t;
  state_t r_state, w_next;
  logic [2*WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_count;
  logic [CW-1:0] r_cnt;
  logic r_armed, r_out_valid, r_out_timeout;
  logic [2*WIDTH-1:0] r_out_result;
  logic [WIDTH-1:0] r_mcand, r_mplier;
  logic w_push, w_pop, w_done, w_tmo, w_empty, w_full;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_empty ? IDLE : START;
      START:   w_next = WAIT;
      WAIT:    w_next = w_pop ? OUT : WAIT;
      default: w_next = out_ready ? IDLE : OUT;
    endcase
  end

  always_comb begin
    w_empty          = r_count == '0;
    w_full           = r_count == (AW+1)'(FIFO_DEPTH);
    in_ready         = reset_n && !w_full;
    w_push           = in_valid && in_ready;
    w_done           = r_state == WAIT && r_armed && mul_finished;
    w_tmo            = r_state == WAIT && !w_done && r_cnt == CW'(TIMEOUT - 1);
    w_pop            = w_done || w_tmo;
    mul_start        = r_state == START;
    mul_multiplicand = r_mcand;
    mul_multiplier   = r_mplier;
    out_valid        = r_out_valid;
    out_result       = r_out_result;
    out_timeout      = r_out_timeout;
    busy             = r_state != IDLE || !w_empty;
  end

  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= {in_a, in_b};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr          <= '0;
      r_rd          <= '0;
      r_count       <= '0;
      r_cnt         <= '0;
      r_armed       <= 1'b0;
      r_mcand       <= '0;
      r_mplier      <= '0;
      r_out_valid   <= 1'b0;
      r_out_timeout <= 1'b0;
      r_out_result  <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (r_state == IDLE && !w_empty) begin
        r_mcand  <= r_mem[r_rd][2*WIDTH-1:WIDTH];
        r_mplier <= r_mem[r_rd][WIDTH-1:0];
      end
      if (r_state == START) begin
        r_armed <= 1'b0;
        r_cnt   <= '0;
      end
      // a finished seen before any low sample belongs to the previous job
      if (r_state == WAIT && !mul_finished) r_armed <= 1'b1;
      if (w_done) begin
        r_out_result  <= mul_result;
        r_out_timeout <= 1'b0;
        r_out_valid   <= 1'b1;
      end else if (w_tmo) begin
        r_out_result  <= '0;
        r_out_timeout <= 1'b1;
        r_out_valid   <= 1'b1;
      end else if (r_state == WAIT) r_cnt <= r_cnt + 1'b1;
      if (r_state == OUT && out_ready) r_out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mult_dispatch.sv
// tb_mult_dispatch: directed and randomized checks of mult_dispatch against a product scoreboard
// and a behavioural multiplier whose finished timing is tunable.
module tb_mult_dispatch;
  localparam int W = 4, D = 4, TO = 31;
  logic clk = 0, reset_n = 1;
  logic in_valid = 0, in_ready;
  logic [W-1:0] in_a = 0, in_b = 0, mul_multiplicand, mul_multiplier;
  logic mul_start, mul_finished = 0, out_valid, out_ready = 0, out_timeout, busy;
  logic [2*W-1:0] mul_result = 0, out_result, m_p = 0;
  int tests = 0, fails = 0, cyc = 0, t_start = 0, starts = 0;
  int m_hold = 0, m_lat = 1, m_cnt = 0;
  bit m_never = 0, m_busy = 0;
  logic [2*W:0] exp_q[$];

  mult_dispatch #(.WIDTH(W), .FIFO_DEPTH(D), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mul_multiplicand(mul_multiplicand),
    .mul_multiplier(mul_multiplier), .mul_start(mul_start), .mul_result(mul_result),
    .mul_finished(mul_finished), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_timeout(out_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return (2*W)'(sa * sb);
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (mul_start) begin
      starts++;
      t_start = cyc;
    end
  end

  // finished drops m_hold cycles after start, rises m_lat cycles later, then stays high
  always @(posedge clk) begin
    if (!reset_n) m_busy <= 0;
    else if (mul_start) begin
      m_busy <= 1;
      m_cnt  <= 0;
      m_p    <= prod(mul_multiplicand, mul_multiplier);
    end else if (m_busy) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == m_hold) mul_finished <= 0;
      if (m_cnt == m_hold + m_lat && !m_never) begin
        mul_finished <= 1;
        mul_result   <= m_p;
        m_busy       <= 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input bit to);
    int k = 0;
    in_valid = 1;
    in_a = a;
    in_b = b;
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("push_ready", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 0;
    exp_q.push_back(to ? {1'b1, {2*W{1'b0}}} : {1'b0, prod(a, b)});
  endtask

  task automatic expect_out(input string tag, input int hold_cycles);
    int k = 0;
    logic [2*W:0] e;
    chk({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 1);
    e = exp_q.size() != 0 ? exp_q.pop_front() : '0;
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_result"}, 32'(out_result), 32'(e[2*W-1:0]));
    chk({tag, "_timeout"}, 32'(out_timeout), 32'(e[2*W]));
    repeat (hold_cycles) @(negedge clk);
    if (hold_cycles > 0) chk({tag, "_held"}, 32'({out_valid, out_timeout, out_result}), 32'({1'b1, e}));
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk({tag, "_valid_drop"}, 32'(out_valid), 0);
  endtask

  initial begin
    int s0, k, sp;
    #1 reset_n = 0;
    #1 chk("rst_outs", 32'({in_ready, busy, out_valid, out_timeout, out_result, mul_start,
                             mul_multiplicand, mul_multiplier}), 0);
    repeat (2) @(negedge clk);
    reset_n = 1;
    #1 chk("rst_rel_ready", 32'({in_ready, busy}), 32'b10);
    @(negedge clk);

    s0 = starts;
    push(4'b0100, 4'b0011, 0);
    chk("single_no_start_yet", 32'(mul_start), 0);
    @(negedge clk);
    chk("single_start_ops", 32'({mul_start, mul_multiplicand, mul_multiplier}), 32'({1'b1, 4'd4, 4'd3}));
    @(negedge clk);
    chk("single_start_pulse", 32'(mul_start), 0);
    expect_out("single", 0);
    chk("single_start_count", 32'(starts - s0), 1);

    push(4'b1101, 4'b0101, 0);
    expect_out("signed", 1);
    chk("signed_busy_low", 32'(busy), 0);

    for (int i = 1; i <= 5; i++) push(W'(i), W'(i), 0);
    repeat (10) @(negedge clk);
    chk("full_ready_low", 32'({in_ready, busy, out_valid}), 32'b011);
    for (int i = 0; i < 5; i++) expect_out("bp", 0);
    repeat (3) @(negedge clk);
    chk("bp_drained", 32'({busy, out_valid, in_ready}), 32'b001);

    m_hold = 3;
    push(4'd2, 4'd3, 0);
    expect_out("stale", 0);
    m_hold = 0;

    m_never = 1;
    push(4'd7, 4'd7, 1);
    push(4'd6, 4'b1110, 0);
    k = 0;
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("tmo_wait_cycles", 32'(cyc - t_start), TO);
    m_never = 0;
    expect_out("tmo", 0);
    expect_out("after_tmo", 0);

    m_never = 1;
    push(4'd5, 4'd6, 0);
    push(4'd1, 4'd2, 0);
    repeat (5) @(negedge clk);
    chk("pre_rst_wait", 32'({busy, mul_multiplicand}), 32'({1'b1, 4'd5}));
    #2 reset_n = 0;
    #1 chk("rst_mid_outs", 32'({in_ready, busy, out_valid, out_timeout, out_result, mul_start,
                                mul_multiplicand, mul_multiplier}), 0);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1;
    m_never = 0;
    #1 chk("rst_mid_rel", 32'({in_ready, busy}), 32'b10);
    sp = 0;
    repeat (10) begin
      @(negedge clk);
      sp += int'(out_valid) + int'(mul_start) + int'(busy);
    end
    chk("rst_mid_quiet", 32'(sp), 0);

    for (int j = 0; j < 12; j++) begin
      int n;
      n = $urandom_range(1, 3);
      m_lat = $urandom_range(1, 4);
      m_hold = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) push(W'($urandom), W'($urandom), 0);
      for (int i = 0; i < n; i++) expect_out("rnd", $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
